// File: rtl/rf_wr_port_arbiter.sv
// Register-file write-port arbiter.
// Shares one RF write port between the in-order writeback stage and a
// long-latency result source. Late results wait in a small FIFO; the pipe
// normally wins, but a non-empty FIFO is force-granted after STARVE_MAX lost
// cycles or when full. query_hit tells decode a register still has a late
// write pending.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   pipe_wr_en_i/pipe_rd_i/pipe_data_i   WB write request
//   pipe_stall_o                     WB lost this cycle, hold inputs (comb)
//   mc_valid_i/mc_rd_i/mc_data_i     late result push
//   mc_ready_o                       FIFO has room (from registered count)
//   query_rd_i/query_hit_o           pending-write lookup (comb)
//   rf_wr_en_o/rf_rd_o/rf_wr_data_o  registered RF write port
module rf_wr_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr_en_i,
  input  logic [REG_AW-1:0] pipe_rd_i,
  input  logic [XLEN-1:0]   pipe_data_i,
  output logic              pipe_stall_o,
  input  logic              mc_valid_i,
  input  logic [REG_AW-1:0] mc_rd_i,
  input  logic [XLEN-1:0]   mc_data_i,
  output logic              mc_ready_o,
  input  logic [REG_AW-1:0] query_rd_i,
  output logic              query_hit_o,
  output logic              rf_wr_en_o,
  output logic [REG_AW-1:0] rf_rd_o,
  output logic [XLEN-1:0]   rf_wr_data_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  // FIFO storage; contents only meaningful where valid_q is set
  logic [REG_AW-1:0]     ent_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0]       ent_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;

  logic              rf_wr_en_q, rf_wr_en_d;
  logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wr_data_q, rf_wr_data_d;

  logic pipe_req, fifo_nonempty, fifo_full, force_grant;
  logic fifo_grant, pipe_grant, push;

  // Arbitration and handshake
  always_comb begin
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    pipe_req      = pipe_wr_en_i && (pipe_rd_i != '0);
    force_grant   = fifo_nonempty && ((starve_q >= STV_W'(STARVE_MAX)) || fifo_full);
    fifo_grant    = fifo_nonempty && (force_grant || !pipe_req);
    pipe_grant    = pipe_req && !fifo_grant;
    pipe_stall_o  = pipe_req && fifo_grant;
    mc_ready_o    = !fifo_full;
    // x0 results complete the handshake but are never stored
    push          = mc_valid_i && mc_ready_o && (mc_rd_i != '0);
  end

  // Pending-write lookup; the entry being popped still counts
  always_comb begin
    query_hit_o = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (valid_q[i] && (ent_rd_q[i] == query_rd_i)) query_hit_o = 1'b1;
    end
    if (query_rd_i == '0) query_hit_o = 1'b0;
  end

  // Next-state for FIFO bookkeeping, starvation counter and RF port
  always_comb begin
    valid_d      = valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_d     = starve_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wr_data_d = rf_wr_data_q;

    if (fifo_grant) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      rf_wr_en_d        = 1'b1;
      rf_rd_d           = ent_rd_q[rd_ptr_q];
      rf_wr_data_d      = ent_data_q[rd_ptr_q];
    end else if (pipe_grant) begin
      rf_wr_en_d   = 1'b1;
      rf_rd_d      = pipe_rd_i;
      rf_wr_data_d = pipe_data_i;
    end

    // Push after pop so a simultaneous push/pop on one slot keeps it valid
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    case ({push, fifo_grant})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (!fifo_nonempty || fifo_grant) starve_d = '0;
    else if (starve_q < STV_W'(STARVE_MAX)) starve_d = starve_q + STV_W'(1);
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_q      <= '0;
      rf_wr_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  // FIFO payload, qualified by valid_q so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= mc_rd_i;
      ent_data_q[wr_ptr_q] <= mc_data_i;
    end
  end

  assign rf_wr_en_o   = rf_wr_en_q;
  assign rf_rd_o      = rf_rd_q;
  assign rf_wr_data_o = rf_wr_data_q;

endmodule
